// File: rtl/regfile_sweep.sv
// 32-entry register file with two combinational read ports and one write port.
// A hardware sweep zeroes the array after reset or on Clear; writes are dropped while Busy.
module regfile_sweep #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [ADDR_BITS-1:0] ReadRegister1,
  input  logic [ADDR_BITS-1:0] ReadRegister2,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2,
  input  logic [ADDR_BITS-1:0] WriteRegister,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic                 RegWrite,
  input  logic                 Clear,
  output logic                 Busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                 r_state;
  logic [ADDR_BITS-1:0]   r_ptr;
  logic                   r_busy;
  logic [WIDTH-1:0]       r_mem [DEPTH];

  logic                   w_sweep_we;
  logic                   w_user_we;
  logic                   w_fwd1;
  logic                   w_fwd2;

  assign w_sweep_we = (r_state == CLEAR);
  assign w_user_we  = (r_state == READY) && !Clear && RegWrite && (WriteRegister != '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= CLEAR;
      r_ptr   <= ADDR_BITS'(1);
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          if (Clear) begin
            r_ptr <= ADDR_BITS'(1);
          end else if (r_ptr == '1) begin
            // ptr parks at 1 so it never reads 0 when the next sweep starts
            r_ptr   <= ADDR_BITS'(1);
            r_state <= READY;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + ADDR_BITS'(1);
          end
        end
        READY: begin
          if (Clear) begin
            r_state <= CLEAR;
            r_ptr   <= ADDR_BITS'(1);
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= ADDR_BITS'(1);
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage is not reset; the sweep is what initialises it.
  always_ff @(posedge Clk) begin
    if (w_sweep_we) begin
      r_mem[r_ptr] <= '0;
    end else if (w_user_we) begin
      r_mem[WriteRegister] <= WriteData;
    end
  end

  assign w_fwd1 = BYPASS && RegWrite && (WriteRegister != '0) && (WriteRegister == ReadRegister1);
  assign w_fwd2 = BYPASS && RegWrite && (WriteRegister != '0) && (WriteRegister == ReadRegister2);

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (!r_busy) begin
      if (ReadRegister1 != '0) ReadData1 = w_fwd1 ? WriteData : r_mem[ReadRegister1];
      if (ReadRegister2 != '0) ReadData2 = w_fwd2 ? WriteData : r_mem[ReadRegister2];
    end
  end

  assign Busy = r_busy;

endmodule

// File: tb/tb_regfile_sweep.sv
// Bench for regfile_sweep: an abstract model (sweep countdown + value array)
// checked every cycle, plus directed scenarios with literal expectations.
module tb_regfile_sweep;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [4:0]  ReadRegister1 = '0;
  logic [4:0]  ReadRegister2 = '0;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  WriteRegister = '0;
  logic [31:0] WriteData = '0;
  logic        RegWrite = 1'b0;
  logic        Clear = 1'b0;
  logic        Busy;

  int checks = 0;
  int errors = 0;

  regfile_sweep #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(1'b1)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .RegWrite(RegWrite), .Clear(Clear), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Model: edges left in the current sweep, and the architectural contents.
  int          m_left = 31;
  logic [31:0] m_mem [32];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n || (m_left > 0 && Clear) || (m_left == 0 && Clear)) begin
      m_left <= 31;
      for (int i = 0; i < 32; i++) m_mem[i] <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (RegWrite && WriteRegister != 0) begin
      m_mem[WriteRegister] <= WriteData;
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (m_left > 0 || a == 0) return 32'd0;
    if (RegWrite && WriteRegister != 0 && WriteRegister == a) return WriteData;
    return m_mem[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  logic cmp_en = 1'b0;
  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("model_busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
      chk("model_rd1", ReadData1, m_read(ReadRegister1));
      chk("model_rd2", ReadData2, m_read(ReadRegister2));
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1; WriteRegister = a; WriteData = d;
    step();
    RegWrite = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2, input string name);
    ReadRegister1 = a1; ReadRegister2 = a2;
    #1;
    chk({name, "_p1"}, ReadData1, e1);
    chk({name, "_p2"}, ReadData2, e2);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (Busy && n < 100) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    #1 cmp_en = 1'b1;
    step(); step();
    chk("reset_busy", {31'd0, Busy}, 32'd1);
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd31;
    #1;
    chk("reset_rd1", ReadData1, 32'd0);
    Reset_n = 1'b1;
    count_busy(n);
    chk("sweep_len_reset", n, 32'd31);
    rd(5, 31, 0, 0, "post_sweep");

    wr(2, 42);
    rd(2, 2, 42, 42, "w42");
    wr(2, 15);
    rd(2, 2, 15, 15, "w15");
    WriteData = 32'd12; step();
    rd(2, 2, 15, 15, "nowrite");

    wr(20, 15);
    wr(1, 32);
    rd(20, 1, 15, 32, "decode");
    rd(2, 2, 15, 15, "decode_r2");

    ReadRegister1 = 0; ReadRegister2 = 0;
    RegWrite = 1'b1; WriteRegister = 0; WriteData = 15;
    #1;
    chk("r0_bypass_p1", ReadData1, 32'd0);
    chk("r0_bypass_p2", ReadData2, 32'd0);
    step(); RegWrite = 1'b0;
    rd(0, 0, 0, 0, "r0_after");

    ReadRegister1 = 7; ReadRegister2 = 8;
    RegWrite = 1'b1; WriteRegister = 7; WriteData = 76;
    #1;
    chk("bypass_p1", ReadData1, 32'd76);
    chk("bypass_p2", ReadData2, 32'd0);
    step(); RegWrite = 1'b0;
    rd(7, 8, 76, 0, "bypass_after");

    // Clear wins over a same-edge write; sweep runs a full 31 edges.
    wr(3, 9);
    rd(3, 4, 9, 0, "pre_clear");
    Clear = 1'b1; RegWrite = 1'b1; WriteRegister = 4; WriteData = 5;
    step();
    Clear = 1'b0; RegWrite = 1'b0;
    chk("clear_busy", {31'd0, Busy}, 32'd1);
    count_busy(n);
    chk("sweep_len_clear", n, 32'd31);
    rd(3, 4, 0, 0, "post_clear");

    // Reset at sweep edge 10 restarts the sweep from scratch.
    wr(3, 9);
    Clear = 1'b1; RegWrite = 1'b1; WriteRegister = 4; WriteData = 5;
    step();
    Clear = 1'b0; RegWrite = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_sweep_busy", {31'd0, Busy}, 32'd1);
    Reset_n = 1'b0;
    step(); step();
    Reset_n = 1'b1;
    count_busy(n);
    chk("sweep_len_rst", n, 32'd31);
    rd(3, 4, 0, 0, "post_rst");
    rd(2, 20, 0, 0, "post_rst_other");

    step(); step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
